// File: rtl/ysyx_22041207_mul_pkg.sv
// Shared constants and state encoding for the iterative RV64 MUL unit.
package ysyx_22041207_mul_pkg;

    localparam int XLEN  = 64;
    localparam int CNT_W = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

endpackage : ysyx_22041207_mul_pkg

// File: rtl/ysyx_22041207_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, returns the
// low XLEN bits of the product with a one-cycle done pulse.
module ysyx_22041207_mul
    import ysyx_22041207_mul_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                mul_valid,
    input  logic                flush,
    input  logic [XLEN-1:0]     multiplicand,
    input  logic [XLEN-1:0]     multiplier,
    output logic                mul_ready,
    output logic                out_valid,
    output logic [XLEN/2-1:0]   result_hi,
    output logic [XLEN/2-1:0]   result_lo
);

    mul_state_e             state_q,  state_d;
    logic [XLEN-1:0]        acc_q,    acc_d;
    logic [XLEN-1:0]        mcand_q,  mcand_d;
    logic [XLEN-1:0]        mplier_q, mplier_d;
    logic [CNT_W-1:0]       cnt_q,    cnt_d;
    logic [XLEN-1:0]        result_q, result_d;
    logic [XLEN-1:0]        acc_sum_s;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    // Next-state and datapath update; flush overrides everything but keeps the last result
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        acc_sum_s = acc_q + (mplier_q[0] ? mcand_q : {XLEN{1'b0}});

        case (state_q)
            ST_IDLE: begin
                if (mul_valid) begin
                    mcand_d  = multiplicand;
                    mplier_d = multiplier;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = ST_BUSY;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_BUSY: begin
                acc_d    = acc_sum_s;
                mcand_d  = {mcand_q[XLEN-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[XLEN-1:1]};
                cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                // The last bit's contribution lands in the result directly
                if (cnt_q == CNT_W'(XLEN - 1)) begin
                    result_d = acc_sum_s;
                    state_d  = ST_DONE;
                end else begin
                    state_d  = ST_BUSY;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (flush) begin
            state_d  = ST_IDLE;
            result_d = result_q;
        end else begin
            result_d = result_d;
        end
    end

    assign mul_ready = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE) && !flush;
    assign result_hi = result_q[XLEN-1:XLEN/2];
    assign result_lo = result_q[XLEN/2-1:0];

endmodule : ysyx_22041207_mul

// File: tb/tb_ysyx_22041207_mul.sv
// Self-checking bench for ysyx_22041207_mul: directed corner cases plus random
// operands compared against a plain-arithmetic truncated product.
module tb_ysyx_22041207_mul;

    logic        clk = 1'b0;
    logic        rst;
    logic        mul_valid;
    logic        flush;
    logic [63:0] multiplicand;
    logic [63:0] multiplier;
    logic        mul_ready;
    logic        out_valid;
    logic [31:0] result_hi;
    logic [31:0] result_lo;

    int checks   = 0;
    int failures = 0;
    logic [63:0] last_result;

    always #5 clk = ~clk;

    ysyx_22041207_mul dut (
        .clk          (clk),
        .rst          (rst),
        .mul_valid    (mul_valid),
        .flush        (flush),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .mul_ready    (mul_ready),
        .out_valid    (out_valid),
        .result_hi    (result_hi),
        .result_lo    (result_lo)
    );

    function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b);
        logic [127:0] full;
        full = {64'd0, a} * {64'd0, b};
        return full[63:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int k);
        k = 0;
        while (!out_valid && k < 70) begin
            step();
            k++;
        end
    endtask

    // Full transaction: accept, fixed latency, result, single pulse, ready again
    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input bit scramble);
        int k;
        logic [63:0] exp;
        exp = ref_mul(a, b);
        check({tag, "_ready_pre"}, 64'(mul_ready), 64'd1);
        multiplicand = a;
        multiplier   = b;
        mul_valid    = 1'b1;
        step();
        mul_valid = 1'b0;
        if (scramble) begin
            multiplicand = {$urandom, $urandom};
            multiplier   = {$urandom, $urandom};
        end
        check({tag, "_ready_busy"}, 64'(mul_ready), 64'd0);
        wait_done(k);
        check({tag, "_latency"}, 64'(k), 64'd64);
        check({tag, "_result"}, {result_hi, result_lo}, exp);
        check({tag, "_ready_done"}, 64'(mul_ready), 64'd0);
        step();
        check({tag, "_pulse_once"}, 64'(out_valid), 64'd0);
        check({tag, "_ready_post"}, 64'(mul_ready), 64'd1);
        last_result = exp;
    endtask

    initial begin
        int k;
        int seen;
        rst          = 1'b0;
        mul_valid    = 1'b0;
        flush        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        last_result  = '0;

        #1;
        check("rst_ready", 64'(mul_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", {result_hi, result_lo}, 64'd0);
        step();
        step();
        rst = 1'b1;
        step();

        run_op("3x5", 64'd3, 64'd5, 1'b0);
        run_op("ffx2", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0);
        check("ffx2_halves", {result_hi, result_lo}, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op("ffxff", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        check("ffxff_halves", {result_hi, result_lo}, 64'h0000_0000_0000_0001);
        run_op("ovf", 64'h1_0000_0000, 64'h1_0000_0000, 1'b0);
        check("ovf_halves", {result_hi, result_lo}, 64'd0);
        run_op("shift", 64'h1234_5678, 64'h10, 1'b0);
        check("shift_halves", {result_hi, result_lo}, 64'h0000_0001_2345_6780);

        // Request held while busy must be ignored
        multiplicand = 64'd7;
        multiplier   = 64'd6;
        mul_valid    = 1'b1;
        step();
        multiplicand = 64'd9;
        multiplier   = 64'd9;
        for (int i = 0; i < 10; i++) step();
        mul_valid = 1'b0;
        wait_done(k);
        check("busy_ign_latency", 64'(k), 64'd54);
        check("busy_ign_result", {result_hi, result_lo}, 64'd42);
        step();
        last_result = 64'd42;

        // Flush mid-run drops the operation
        multiplicand = 64'd2;
        multiplier   = 64'd2;
        mul_valid    = 1'b1;
        step();
        mul_valid = 1'b0;
        for (int i = 0; i < 9; i++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_ready", 64'(mul_ready), 64'd1);
        seen = 0;
        for (int i = 0; i < 70; i++) begin
            if (out_valid) seen++;
            step();
        end
        check("flush_no_valid", 64'(seen), 64'd0);
        check("flush_result_kept", {result_hi, result_lo}, last_result);
        run_op("4x4", 64'd4, 64'd4, 1'b0);

        // Flush during the done cycle suppresses the pulse only
        multiplicand = 64'd11;
        multiplier   = 64'd13;
        mul_valid    = 1'b1;
        step();
        mul_valid = 1'b0;
        wait_done(k);
        check("dflush_latency", 64'(k), 64'd64);
        flush = 1'b1;
        #1;
        check("dflush_suppress", 64'(out_valid), 64'd0);
        step();
        flush = 1'b0;
        check("dflush_ready", 64'(mul_ready), 64'd1);
        check("dflush_result", {result_hi, result_lo}, 64'd143);

        // Asynchronous reset mid-run
        multiplicand = 64'd5;
        multiplier   = 64'd5;
        mul_valid    = 1'b1;
        step();
        mul_valid = 1'b0;
        for (int i = 0; i < 19; i++) step();
        #2;
        rst = 1'b0;
        #1;
        check("arst_ready", 64'(mul_ready), 64'd1);
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_result", {result_hi, result_lo}, 64'd0);
        step();
        step();
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 70; i++) begin
            if (out_valid) seen++;
            step();
        end
        check("arst_no_valid", 64'(seen), 64'd0);
        run_op("5x5", 64'd5, 64'd5, 1'b0);

        // Back-to-back cadence: request raised in DONE is taken at E66
        multiplicand = 64'd10;
        multiplier   = 64'd10;
        mul_valid    = 1'b1;
        step();
        mul_valid = 1'b0;
        wait_done(k);
        multiplicand = 64'd3;
        multiplier   = 64'd7;
        mul_valid    = 1'b1;
        step();
        check("cad_ready_e65", 64'(mul_ready), 64'd1);
        step();
        mul_valid = 1'b0;
        check("cad_accept_e66", 64'(mul_ready), 64'd0);
        wait_done(k);
        check("cad_latency", 64'(k), 64'd64);
        check("cad_result", {result_hi, result_lo}, 64'd21);
        step();

        // flush and mul_valid together in IDLE: request dropped
        multiplicand = 64'd8;
        multiplier   = 64'd8;
        mul_valid    = 1'b1;
        flush        = 1'b1;
        step();
        mul_valid = 1'b0;
        flush     = 1'b0;
        check("fv_ready", 64'(mul_ready), 64'd1);
        seen = 0;
        for (int i = 0; i < 70; i++) begin
            if (out_valid) seen++;
            step();
        end
        check("fv_no_valid", 64'(seen), 64'd0);
        check("fv_result_kept", {result_hi, result_lo}, 64'd21);

        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("rnd%0d", i), {$urandom, $urandom}, {$urandom, $urandom}, i[0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ysyx_22041207_mul

// File: doc/ysyx_22041207_mul.md
Name: ysyx_22041207_mul

Overview:
Iterative shift-add multiplier used by the CPU ALU for the RV64 MUL operation. It takes two 64-bit operands through a valid/ready handshake and returns the low 64 bits of the product, split into two 32-bit halves. The result is accompanied by a one-cycle done pulse. A pipeline flush aborts any operation in flight.

Parameters:
XLEN, 64, operand width; the result halves are XLEN/2 bits each.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  reset; asynchronous, active-low.
mul_valid  input  1  start request; sampled only when mul_ready=1.
flush  input  1  synchronous abort; discards any operation in flight.
multiplicand  input  XLEN  operand A.
multiplier  input  XLEN  operand B.
mul_ready  output  1  high when idle and able to accept a request.
out_valid  output  1  one-cycle pulse: result is valid.
result_hi  output  XLEN/2  product[63:32].
result_lo  output  XLEN/2  product[31:0].

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, mul_ready=1, out_valid=0.
  - result_hi=0, result_lo=0; internal accumulator and counter cleared.
- States: IDLE, BUSY, DONE. mul_ready=1 only in IDLE.
- IDLE:
  - On an edge with mul_valid=1 and flush=0: latch both operands, clear the accumulator, set counter=0, go to BUSY (edge E0).
  - mul_valid with mul_ready=0 is ignored; operands are not re-sampled.
- BUSY, one multiplier bit per edge (E1..E64):
  - If multiplier_reg[0]=1, acc += multiplicand_reg.
  - multiplicand_reg <<= 1; multiplier_reg >>= 1; counter++.
  - All arithmetic is modulo 2^64; bits shifted out are discarded.
  - At E64 (counter reaches XLEN): copy acc into result_hi/result_lo and go to DONE.
- DONE: out_valid=1 for exactly this one cycle; next edge returns to IDLE with mul_ready=1.
- Fixed latency: out_valid is high in the cycle after E64. The next request can be accepted at E66, i.e. 66 edges after the previous accept.
- Signedness: unsigned truncated product. This equals the RV64 MUL low 64 bits for signed operands too; no high-half or signed-high variants.
- result_hi/result_lo hold their last completed value until the next completion. They are not updated by flush or by a new accept.
- Flush (synchronous, priority below reset, above everything else):
  - In any state, go to IDLE; out_valid=0 that cycle; mul_ready=1 next cycle.
  - flush and mul_valid on the same edge: the request is dropped.
  - flush in DONE suppresses out_valid for that cycle.
- Reset asserted mid-operation: everything returns immediately to reset values; no out_valid is produced.
- Operands are not required to stay stable after acceptance.

Decomposition:
- Shared package (ysyx_22041207_mul_pkg) holds:
  - the XLEN constant;
  - the state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2);
  - the counter width, clog2(XLEN)+1.
- No sub-module: one FSM plus a datapath (accumulator, two shift registers, counter) in a single module.

Test Plan:
- After reset: mul_ready=1, out_valid=0, result=0. Then 3*5 accepted at E0 -> out_valid high exactly one cycle after E64; result_hi=0x00000000, result_lo=0x0000000F; mul_ready=1 after E65.
- 0xFFFFFFFFFFFFFFFF * 2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE. Then 0xFFFFFFFFFFFFFFFF * 0xFFFFFFFFFFFFFFFF -> hi=0x00000000, lo=0x00000001.
- 0x100000000 * 0x100000000 -> hi=0, lo=0 (overflow truncated). 0x12345678 * 0x10 -> hi=0x00000001, lo=0x23456780.
- Accept 7*6; at cycle 10 hold mul_valid=1 with operands 9*9 -> ignored, result is 42. Assert flush at cycle 10 of a second run (2*2) -> no out_valid, mul_ready=1 next cycle, result still 42. A new 4*4 then gives 16.
- Drive rst low at cycle 20 of a 5*5 run -> immediate idle, result=0, no out_valid. After release, 5*5 -> 25 with full 66-edge cadence.
- Assert flush and mul_valid on the same edge in IDLE -> request dropped, mul_ready stays 1, no out_valid within 70 cycles.
